// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with a sequential
// clear engine. Register writes are sampled on the rising clock edge, and
// reads are combinational. A clear request sweeps every register to zero,
// one register per cycle, and busy is held high for the whole sweep.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write
// issued in IDLE is forwarded to any read port that addresses the same
// register in the same cycle.
module regfile_mp #(
  parameter int WIDTH    = 8,
  parameter int REGBITS  = 3,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [REGBITS-1:0]       wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [NREAD*REGBITS-1:0] ra,
  output logic [NREAD*WIDTH-1:0]   rd,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] CNT_ZERO = REGBITS'(0);
  localparam logic [REGBITS-1:0] CNT_ONE  = REGBITS'(1);
  localparam logic [REGBITS-1:0] CNT_LAST = REGBITS'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [REGBITS-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 clr_done_q, clr_done_d;
  logic                 wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic                 write_en_s;
  logic [NREAD*WIDTH-1:0] rd_s;

  // True when the address selects the hardwired-zero register.
  function automatic logic is_zero_addr(input logic [REGBITS-1:0] addr);
    return (ZERO_REG != 0) && (addr == CNT_ZERO);
  endfunction

  // State, sweep counter and status flags. Reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Next state and sweep counter. In IDLE, clr_req starts a sweep. In CLEAR,
  // the sweep ends on the edge that clears the last index, and clr_req is
  // ignored during the whole sweep, including that final edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Registered status outputs. busy follows the next state. clr_done marks
  // the return from CLEAR to IDLE. wr_drop flags a write that arrived while
  // a sweep was running.
  always_comb begin
    busy_d     = 1'b0;
    clr_done_d = 1'b0;
    wr_drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d     = (state_d == ST_CLEAR);
        clr_done_d = 1'b0;
        wr_drop_d  = 1'b0;
      end
      ST_CLEAR: begin
        busy_d     = (state_d == ST_CLEAR);
        clr_done_d = (state_d == ST_IDLE);
        wr_drop_d  = we;
      end
      default: begin
        busy_d     = 1'b0;
        clr_done_d = 1'b0;
        wr_drop_d  = 1'b0;
      end
    endcase
  end

  // A write is accepted only in IDLE. A write to the hardwired zero register
  // is discarded.
  always_comb begin
    write_en_s = (state_q == ST_IDLE) && we && !is_zero_addr(wa);
  end

  // Next storage contents. The sweep clear is applied after the write, so a
  // same-edge write and clear request is overwritten later by the sweep.
  always_comb begin
    mem_d = mem_q;
    if (write_en_s) begin
      mem_d[wa] = wd;
    end else begin
      mem_d[wa] = mem_q[wa];
    end
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q] = {WIDTH{1'b0}};
    end else begin
      mem_d[cnt_q] = mem_d[cnt_q];
    end
  end

  // Register storage. Reset clears every register immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    rd_s = {(NREAD*WIDTH){1'b0}};
    for (int p = 0; p < NREAD; p++) begin
      if (is_zero_addr(ra[p*REGBITS +: REGBITS])) begin
        rd_s[p*WIDTH +: WIDTH] = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (write_en_s && (ra[p*REGBITS +: REGBITS] == wa)) begin
        rd_s[p*WIDTH +: WIDTH] = wd;
`endif
      end else begin
        rd_s[p*WIDTH +: WIDTH] = mem_q[ra[p*REGBITS +: REGBITS]];
      end
    end
  end

  assign rd       = rd_s;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with the default parameters: WIDTH=8,
// REGBITS=3, NREAD=2 and ZERO_REG=1.
// The stimulus process pushes hand-computed expectations into a queue and
// raises chk_ev. The monitor process pops each entry and compares it with
// the DUT outputs.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n;
  logic        we;
  logic [2:0]  wa;
  logic [7:0]  wd;
  logic [5:0]  ra;
  logic [15:0] rd;
  logic        clr_req;
  logic        busy;
  logic        clr_done;
  logic        wr_drop;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } chk_t;

  chk_t sb_q[$];
  event chk_ev;

  regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rd       (rd),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  // Output selectors: 0 = rd port 0, 1 = rd port 1, 2 = busy, 3 = clr_done, 4 = wr_drop.
  function automatic logic [7:0] dut_out(input int sel);
    case (sel)
      0: return rd[7:0];
      1: return rd[15:8];
      2: return {7'd0, busy};
      3: return {7'd0, clr_done};
      4: return {7'd0, wr_drop};
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: pops the expectations and compares them with the DUT outputs.
  initial begin
    chk_t c;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        act = dut_out(c.sel);
        n_total++;
        if (act === c.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  task automatic flush();
    ->chk_ev;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [2:0] a0, input logic [2:0] a1);
    ra = {a1, a0};
  endtask

  // Watchdog: stops the run if the stimulus never finishes.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; we = 1'b0; wa = 3'd0; wd = 8'h00; ra = 6'd0; clr_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    set_ra(3'd0, 3'd1);
    expect_out("reset_busy", 2, 8'h00);
    expect_out("reset_clr_done", 3, 8'h00);
    expect_out("reset_wr_drop", 4, 8'h00);
    expect_out("reset_rd0", 0, 8'h00);
    expect_out("reset_rd1", 1, 8'h00);
    flush();

    // Write then read on both ports
    we = 1'b1; wa = 3'd5; wd = 8'hA5;
    step();
    we = 1'b0;
    set_ra(3'd5, 3'd5);
    expect_out("wr5_rd0", 0, 8'hA5);
    expect_out("wr5_rd1", 1, 8'hA5);
    flush();

    // Hardwired zero register
    we = 1'b1; wa = 3'd0; wd = 8'hFF;
    step();
    we = 1'b0;
    set_ra(3'd0, 3'd0);
    expect_out("zero_rd0", 0, 8'h00);
    expect_out("zero_rd1", 1, 8'h00);
    flush();

    // Bypass: register 3 is visible before the edge only with forwarding
    we = 1'b1; wa = 3'd3; wd = 8'h3C;
    set_ra(3'd3, 3'd5);
`ifdef REGFILE_BYPASS_EN
    expect_out("bypass_rd0_pre", 0, 8'h3C);
`else
    expect_out("nobypass_rd0_pre", 0, 8'h00);
`endif
    expect_out("bypass_rd1_other", 1, 8'hA5);
    flush();
    step();
    we = 1'b0;
    expect_out("wr3_rd0_post", 0, 8'h3C);
    flush();

    // Asynchronous reset with the clock stopped
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("stopped_rst_rd0", 0, 8'h00);
    expect_out("stopped_rst_rd1", 1, 8'h00);
    expect_out("stopped_rst_busy", 2, 8'h00);
    flush();
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;

    // Fill registers 1..7 with 11..77
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = 8'(i * 17);
      step();
    end
    we = 1'b0;
    set_ra(3'd4, 3'd7);
    expect_out("fill_rd4", 0, 8'h44);
    expect_out("fill_rd7", 1, 8'h77);
    flush();

    // Clear sweep. clr_req is taken at edge k, and register i is cleared at edge k+1+i.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    expect_out("sweep_k_busy", 2, 8'h01);
    expect_out("sweep_k_rd4", 0, 8'h44);
    flush();
    for (int j = 1; j <= 9; j++) begin
      step();
      expect_out($sformatf("sweep_busy_j%0d", j), 2, (j < 8) ? 8'h01 : 8'h00);
      expect_out($sformatf("sweep_done_j%0d", j), 3, (j == 8) ? 8'h01 : 8'h00);
      expect_out($sformatf("sweep_drop_j%0d", j), 4, (j == 4) ? 8'h01 : 8'h00);
      expect_out($sformatf("sweep_rd4_j%0d", j), 0, (j >= 5) ? 8'h00 : 8'h44);
      expect_out($sformatf("sweep_rd7_j%0d", j), 1, (j >= 8) ? 8'h00 : 8'h77);
      flush();
      if (j == 3) begin we = 1'b1; wa = 3'd2; wd = 8'h5A; end
      if (j == 4) we = 1'b0;
      if (j == 5) clr_req = 1'b1;
      if (j == 8) clr_req = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      set_ra(3'(i), 3'd2);
      expect_out($sformatf("post_sweep_rd_r%0d", i), 0, 8'h00);
      flush();
    end
    expect_out("post_sweep_rd2", 1, 8'h00);
    flush();

    // Same-edge write and clear request in IDLE
    we = 1'b1; wa = 3'd6; wd = 8'h66; clr_req = 1'b1;
    set_ra(3'd6, 3'd1);
    step();
    we = 1'b0; clr_req = 1'b0;
    expect_out("same_edge_rd6", 0, 8'h66);
    expect_out("same_edge_busy", 2, 8'h01);
    flush();
    repeat (8) step();
    expect_out("same_edge_end_busy", 2, 8'h00);
    expect_out("same_edge_end_done", 3, 8'h01);
    expect_out("same_edge_end_rd6", 0, 8'h00);
    flush();
    step();
    expect_out("same_edge_done_once", 3, 8'h00);
    flush();

    // Reset in the middle of a sweep
    we = 1'b1; wa = 3'd5; wd = 8'h55;
    step();
    wa = 3'd7; wd = 8'h77;
    step();
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (3) step();
    set_ra(3'd5, 3'd7);
    expect_out("midsweep_rd5", 0, 8'h55);
    expect_out("midsweep_rd7", 1, 8'h77);
    expect_out("midsweep_busy", 2, 8'h01);
    flush();
    rst_n = 1'b0;
    #1;
    expect_out("midrst_busy", 2, 8'h00);
    expect_out("midrst_rd5", 0, 8'h00);
    expect_out("midrst_rd7", 1, 8'h00);
    expect_out("midrst_done", 3, 8'h00);
    flush();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      expect_out($sformatf("after_rst_done_c%0d", j), 3, 8'h00);
      expect_out($sformatf("after_rst_busy_c%0d", j), 2, 8'h00);
      flush();
    end

    // Every pushed expectation must have been consumed
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file; the next generation of the datapath register file. Adds N read ports, write-through bypass, asynchronous reset and a sequential clear engine that sweeps all registers to zero under a busy handshake. Sits in the datapath between the control FSM and the ALU/counter logic.

Parameters:
WIDTH, 8, data width of each register
REGBITS, 3, address width; depth = 2**REGBITS
NREAD, 2, number of combinational read ports (>=1)
ZERO_REG, 1, 1: register 0 is hardwired zero (reads 0, writes discarded); 0: register 0 is ordinary

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable, sampled on rising clk
wa  input  REGBITS  write address
wd  input  WIDTH  write data
ra  input  NREAD*REGBITS  packed read addresses; port p uses ra[p*REGBITS +: REGBITS]
rd  output  NREAD*WIDTH  packed read data; port p on rd[p*WIDTH +: WIDTH]
clr_req  input  1  request a full clear sweep
busy  output  1  clear sweep in progress; writes are ignored
clr_done  output  1  one-cycle pulse when the sweep completes
wr_drop  output  1  one-cycle pulse: a write was ignored because busy was high

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, state IDLE, sweep counter = 0, busy = 0, clr_done = 0, wr_drop = 0. rd reflects zeroed storage immediately.
- State machine: IDLE, CLEAR. busy, clr_done and wr_drop are registered outputs.
- IDLE: at a rising edge with we=1, reg[wa] <= wd (discarded if ZERO_REG=1 and wa=0). clr_req=1 at edge k: state -> CLEAR, counter <= 0, busy=1 after edge k.
- Same-edge we and clr_req in IDLE: the write is performed, then the sweep overwrites it.
- CLEAR: at edge k+1+i, reg[i] <= 0 and counter increments, for i = 0 .. 2**REGBITS-1. At edge k+2**REGBITS: state -> IDLE, busy=0, clr_done=1 for exactly one cycle. Total busy duration = 2**REGBITS cycles.
- CLEAR and we=1: the write is not performed; wr_drop=1 in the following cycle. clr_req in CLEAR is ignored and the sweep does not restart. clr_req on the same edge that returns to IDLE is ignored; it must be re-asserted.
- Read: combinational. rd_p = reg[ra_p], or 0 when ZERO_REG=1 and ra_p=0. Out-of-range addresses cannot occur because depth is a full power of two.
- During CLEAR, reads return current storage: swept indices read 0, unswept indices read their old value.
- Reset asserted mid-sweep: the sweep aborts immediately, to IDLE with all outputs at reset values.
- No width conversion: wd and rd are exactly WIDTH bits.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass. In IDLE with we=1, each port with ra_p == wa returns wd in the same cycle, before the edge. No bypass when busy=1, and none for address 0 when ZERO_REG=1.
- Undefined: rd shows stored contents only; new data is visible the cycle after the write edge.

Test Plan:
- Reset then read: rst_n low mid-cycle with clk stopped -> all rd ports = 0 immediately; busy=0.
- Write/read: we=1, wa=5, wd=8'hA5, edge; ra port0=5, port1=5 -> both rd = 8'hA5. Write wa=0, wd=8'hFF with ZERO_REG=1 -> reads of 0 return 8'h00.
- Bypass: with REGFILE_BYPASS_EN, we=1, wa=3, wd=8'h3C, ra0=3 before the edge -> rd0 = 8'h3C same cycle. Without the macro -> rd0 = old value until after the edge.
- Clear sweep: fill regs 1..7 with 8'h11..8'h77, pulse clr_req -> busy high for exactly 8 cycles; reg 4 reads 8'h44 until its sweep edge, then 0; clr_done pulses once; all regs 0 afterwards.
- Write during sweep: we=1, wa=2, wd=8'h5A while busy=1 -> wr_drop pulses one cycle; reg 2 = 0 after the sweep. Same-edge we with clr_req in IDLE -> the written value is cleared.
- Reset mid-sweep: rst_n low at sweep cycle 3 -> busy=0 and all regs 0 immediately; no clr_done pulse after rst_n releases.
